// File: rtl/gcd_ctrl_pkg.sv
// Shared types and select encodings for the GCD controller and its datapath.
package gcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic SEL_A    = 1'b1;
  localparam logic SEL_B    = 1'b0;
  localparam logic BUS_DATA = 1'b1;
  localparam logic BUS_SUB  = 1'b0;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction counter with a terminal compare against the iteration limit.
module gcd_iter_counter #(
  parameter int                ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ITER_W-1:0] cnt,
  output logic              at_max
);

  assign at_max = (cnt == MAX_ITER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the subtract-and-compare GCD datapath: operand handshake,
// Mealy load/select strobes, bounded iteration with timeout error.
//
// state   | meaning
// IDLE    | waiting for operand A
// WAIT_B  | A loaded, waiting for operand B
// RUN     | one subtraction (or finish) per cycle
// DONE    | one-cycle completion pulse, result in A
module gcd_controller
  import gcd_ctrl_pkg::*;
#(
  parameter int                ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_load,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t state;
  state_t next_state;
  logic   cnt_clr;
  logic   cnt_en;
  logic   set_err;
  logic   at_max;
  logic   flags_ok;

  assign flags_ok = $onehot({lt, gt, eq});

  gcd_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (iter_cnt),
    .at_max (at_max)
  );

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = SEL_B;
    sel2       = SEL_B;
    sel_load   = BUS_SUB;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    set_err    = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !clear) begin
          ldA        = 1'b1;
          sel_load   = BUS_DATA;
          cnt_clr    = 1'b1;
          next_state = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && !clear) begin
          ldB        = 1'b1;
          sel_load   = BUS_DATA;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!clear) begin
          // An illegal flag pattern finishes like eq so nothing is ever loaded on it.
          if (eq || !flags_ok) begin
            next_state = ST_DONE;
          end else if (at_max) begin
            set_err    = 1'b1;
            next_state = ST_DONE;
          end else if (gt) begin
            sel1   = SEL_A;
            sel2   = SEL_B;
            ldA    = 1'b1;
            cnt_en = 1'b1;
          end else begin
            sel1   = SEL_B;
            sel2   = SEL_A;
            ldB    = 1'b1;
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = !clear;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    if (clear) begin
      next_state = ST_IDLE;
    end

    // Reset is asynchronous; keep the Mealy strobes quiet while it is held.
    if (rst) begin
      ldA      = 1'b0;
      ldB      = 1'b0;
      sel_load = BUS_SUB;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      set_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (cnt_clr) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural datapath, vector table and a done-time scoreboard.
module tb_gcd_controller;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] data_in;
  logic         lt, gt, eq;
  logic         in_ready, ldA, ldB, sel1, sel2, sel_load, busy, done, err;
  logic [W-1:0] iter_cnt;

  always #5 clk = ~clk;

  gcd_controller #(.ITER_W(W), .MAX_ITER(16'd8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .lt(lt), .gt(gt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2),
    .sel_load(sel_load), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  // Datapath model: A/B registers, operand muxes, subtractor, comparator
  logic [W-1:0] a_reg = '0, b_reg = '0;
  logic [W-1:0] minu, subt, diff;
  logic         force_en = 1'b0;
  logic [2:0]   force_flags = 3'b000;

  assign minu = sel1 ? a_reg : b_reg;
  assign subt = sel2 ? a_reg : b_reg;
  assign diff = minu - subt;

  always @(posedge clk) begin
    if (ldA) a_reg <= sel_load ? data_in : diff;
    if (ldB) b_reg <= sel_load ? data_in : diff;
  end

  always_comb begin
    if (force_en) {lt, gt, eq} = force_flags;
    else          {lt, gt, eq} = {a_reg < b_reg, a_reg > b_reg, a_reg == b_reg};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] g;
    int           iter;
    logic         e;
    int           start;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: count subtraction loads and compare at each done pulse
  int sub_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sub_cnt = 0;
    end else begin
      if (in_valid && in_ready) sub_cnt = 0;
      if ((ldA || ldB) && !sel_load) sub_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("iter_cnt", {16'd0, iter_cnt}, e.iter);
          chk("err", {31'd0, err}, {31'd0, e.e});
          chk("latency", cyc - e.start, e.iter + 2);
          chk("sub_loads", sub_cnt, e.iter);
          chk("busy_in_done", {31'd0, busy}, 32'd1);
          if (!e.e) chk("result", {16'd0, a_reg}, {16'd0, e.g});
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_loads"}, {30'd0, ldA, ldB}, 32'd0);
    chk({tag, "_sels"}, {29'd0, sel1, sel2, sel_load}, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_iter"}, {16'd0, iter_cnt}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                         input logic [W-1:0] g, input int iter, input logic e);
    exp_t x;
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_for_a", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; data_in = a;
    #2 chk("ldA_on_accept", {29'd0, ldA, ldB, sel_load}, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = 16'hDEAD;
    for (int i = 0; i < gap; i++) begin
      #2;
      chk("gap_ready", {31'd0, in_ready}, 32'd1);
      chk("gap_noload", {30'd0, ldA, ldB}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; data_in = b;
    x.g = g; x.iter = iter; x.e = e; x.start = cyc;
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = 16'hDEAD;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("done_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           gap;
    logic [W-1:0] g;
    int           iter;
    logic         e;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [2:0] bad_flags[2];
    tbl[0] = '{16'd48,  16'd18, 0, 16'd6,  4, 1'b0};
    tbl[1] = '{16'd7,   16'd7,  0, 16'd7,  0, 1'b0};
    tbl[2] = '{16'd0,   16'd5,  0, 16'd0,  8, 1'b1};
    tbl[3] = '{16'd35,  16'd14, 3, 16'd7,  3, 1'b0};
    tbl[4] = '{16'd5,   16'd0,  1, 16'd0,  8, 1'b1};
    tbl[5] = '{16'd1,   16'd8,  0, 16'd1,  7, 1'b0};
    tbl[6] = '{16'd1,   16'd9,  0, 16'd1,  8, 1'b0};
    tbl[7] = '{16'd1,   16'd10, 0, 16'd0,  8, 1'b1};
    tbl[8] = '{16'd12,  16'd8,  2, 16'd4,  2, 1'b0};
    tbl[9] = '{16'd100, 16'd75, 0, 16'd25, 3, 1'b0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; data_in = 16'd5;
    @(posedge clk); @(posedge clk); #1;
    chk_reset("reset");
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      present(tbl[i].a, tbl[i].b, tbl[i].gap, tbl[i].g, tbl[i].iter, tbl[i].e);
      wait_done();
      @(posedge clk); #1;
      chk("iter_hold", {16'd0, iter_cnt}, tbl[i].iter);
      chk("idle_after_done", {30'd0, in_ready, busy}, 32'd2);
    end

    // Reset on the second RUN cycle of 48/18
    in_valid = 1'b1; data_in = 16'd48; @(posedge clk); #1;
    data_in = 16'd18; @(posedge clk); #1;
    in_valid = 1'b0; @(posedge clk); #1;
    rst = 1'b1; #1;
    chk_reset("rst_mid_run");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    present(16'd35, 16'd14, 0, 16'd7, 3, 1'b0);
    wait_done();

    // Clear on the second RUN cycle of 48/18
    @(posedge clk); #1;
    in_valid = 1'b1; data_in = 16'd48; @(posedge clk); #1;
    data_in = 16'd18; @(posedge clk); #1;
    in_valid = 1'b0; @(posedge clk); #1;
    clear = 1'b1;
    #2 chk("clear_noload", {30'd0, ldA, ldB}, 32'd0);
    chk("clear_nodone", {31'd0, done}, 32'd0);
    @(posedge clk); #1; clear = 1'b0;
    #1 chk("clear_idle", {30'd0, in_ready, busy}, 32'd2);
    chk("clear_iter_held", {16'd0, iter_cnt}, 32'd1);
    chk("clear_err_held", {31'd0, err}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    present(16'd100, 16'd75, 0, 16'd25, 3, 1'b0);
    wait_done();

    // Illegal comparator patterns finish without loading
    bad_flags[0] = 3'b000;
    bad_flags[1] = 3'b110;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      present(16'd48, 16'd18, 0, 16'd48, 0, 1'b0);
      force_en = 1'b1; force_flags = bad_flags[k];
      #2 chk("bad_flags_noload", {30'd0, ldA, ldB}, 32'd0);
      @(posedge clk); #1;
      force_en = 1'b0;
      wait_done();
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- FSM that sequences the 16-bit subtract-and-compare GCD datapath (registers A/B, three 2:1 muxes, subtractor, comparator).
- Accepts two operands over a valid/ready handshake on the shared data bus, then drives load/select strobes until the datapath reports A==B.
- Reports completion, iteration count and a timeout error. Result is read from datapath register A.
- Bounds iterations so a zero operand, which never converges, cannot hang the block.

Parameters:
- ITER_W, 16, width of iteration counter and MAX_ITER.
- MAX_ITER, 16'hFFFF, RUN-cycle subtraction limit before abort; must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  data_in carries an operand this cycle
- in_ready  output  1  controller accepts an operand this cycle
- lt  input  1  datapath A<B
- gt  input  1  datapath A>B
- eq  input  1  datapath A==B
- ldA  output  1  load register A from bus
- ldB  output  1  load register B from bus
- sel1  output  1  subtractor minuend: 1=A, 0=B
- sel2  output  1  subtractor subtrahend: 1=A, 0=B
- sel_load  output  1  bus source: 1=data_in, 0=subtractor
- busy  output  1  high from A accept through the DONE state
- done  output  1  one-cycle pulse; result valid in A
- err  output  1  valid with done; 1=MAX_ITER reached without eq
- iter_cnt  output  ITER_W  subtractions performed; held after done until next A accept

Behaviour:
- States: IDLE, WAIT_B, RUN, DONE.
- While rst is high: state=IDLE, iter_cnt=0, err=0. ldA/ldB/done/busy/sel1/sel2/sel_load=0. in_ready=1.
- Strobes are decoded combinationally from state and inputs (Mealy). err and iter_cnt are registered.
- IDLE: in_ready=1. On in_valid: ldA=1 and sel_load=1 that cycle, iter_cnt←0, err←0, go to WAIT_B.
- WAIT_B: in_ready=1, busy=1. On in_valid: ldB=1 and sel_load=1, go to RUN. Otherwise hold with no loads for any number of cycles.
- RUN: in_ready=0, busy=1, sel_load=0. Exactly one action per cycle, checked in this priority:
  - eq: no load; go to DONE.
  - iter_cnt==MAX_ITER: no load; err←1; go to DONE.
  - gt: sel1=1, sel2=0, ldA=1; iter_cnt+1.
  - lt: sel1=0, sel2=1, ldB=1; iter_cnt+1.
- Comparator flags are combinational from A/B and are sampled in the cycle after each load.
- DONE: done=1 and busy=1 for one cycle; go to IDLE. in_ready=0.
- Latency from B accept to the done cycle = N+2 cycles, where N = number of subtractions.
- Invalid flag combinations (none set, or more than one set) are treated as eq. The block must never load on an invalid combination.
- clear: highest synchronous priority in every state. Go to IDLE with no load that cycle. iter_cnt and err keep their values; done is not pulsed.
- rst mid-operation: immediate return to the reset values above. Datapath register contents are don't-care.
- iter_cnt never wraps; it is bounded by MAX_ITER.

Decomposition:
- gcd_ctrl_pkg: state enum and encoding, plus select constants (SEL_A=1, SEL_B=0, BUS_DATA=1, BUS_SUB=0).
- One sub-module, gcd_iter_counter: clear and enable inputs, limit-compare output `at_max`.
- Next-state and strobe decode stay in gcd_controller.

Test Plan:
- A=48, B=18 back-to-back (A accepted cycle 0) -> RUN loads ldA, ldA, ldB, ldA; done at cycle 7; iter_cnt=4; err=0; A=6.
- A=7, B=7 -> no subtraction; done 2 cycles after B accept; iter_cnt=0; err=0.
- MAX_ITER=8, A=0, B=5 -> 8 ldB pulses, then done with err=1 and iter_cnt=8; no load in the abort cycle.
- A=35, then in_valid low 3 cycles, then B=14 -> in_ready=1 with no loads during the gap; result 7; iter_cnt=3.
- rst pulsed on the 2nd RUN cycle of 48/18 -> outputs at reset values immediately. New operation 35/14 -> correct result 7.
- clear asserted in RUN -> IDLE next cycle, no done pulse, in_ready=1. Next operation runs normally.
